// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period modes, control/guard-band symbols and the TERC4 table.
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL     = 3'd0,
      MODE_VID_GB   = 3'd1,
      MODE_VIDEO    = 3'd2,
      MODE_DATA_GB  = 3'd3,
      MODE_DATA_ISL = 3'd4
   } tmds_mode_e;

   localparam logic [9:0] CTRL_SYM_00  = 10'h354;
   localparam logic [9:0] CTRL_SYM_01  = 10'h0AB;
   localparam logic [9:0] CTRL_SYM_10  = 10'h154;
   localparam logic [9:0] CTRL_SYM_11  = 10'h2AB;
   localparam logic [9:0] GB_PATTERN_A = 10'h2CC;
   localparam logic [9:0] GB_PATTERN_B = 10'h133;

   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
   };

   // Undefined mode codes 5..7 fold onto CTRL.
   function automatic tmds_mode_e decode_mode(input logic [2:0] raw);
      case (raw)
         3'd1:    return MODE_VID_GB;
         3'd2:    return MODE_VIDEO;
         3'd3:    return MODE_DATA_GB;
         3'd4:    return MODE_DATA_ISL;
         default: return MODE_CTRL;
      endcase
   endfunction

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
      case (c)
         2'b00:   return CTRL_SYM_00;
         2'b01:   return CTRL_SYM_01;
         2'b10:   return CTRL_SYM_10;
         default: return CTRL_SYM_11;
      endcase
   endfunction

   function automatic logic [9:0] terc4_symbol(input logic [3:0] t);
      return TERC4_TABLE[t];
   endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 transition-minimises the byte, stage 2 picks the
// period symbol and tracks running disparity. TERC4 periods need TMDS_TERC4_EN.
module tmds_lane
   import tmds_pkg::*;
#(
   parameter bit GB_USE_B = 1'b0,
   parameter bit IS_LANE0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        mode,
   input  logic [7:0]        vid_data,
   input  logic [1:0]        ctrl,
   input  logic [3:0]        terc4,
   output logic [9:0]        q,
   output logic signed [4:0] disp
);

   tmds_mode_e        mode_s1;
   logic [8:0]        q_m_s1;
   logic [1:0]        ctrl_s1;
   logic [8:0]        q_m_next;
   logic [3:0]        n1_d;
   logic              use_xnor;
   logic              chain;
   logic [3:0]        n1_qm;
   logic signed [4:0] n1_s;
   logic signed [4:0] bal;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_next;
   logic signed [4:0] video_cnt;
   logic [9:0]        video_sym;
   logic [9:0]        q_next;

`ifdef TMDS_TERC4_EN
   logic [3:0] terc4_s1;
`else
   wire unused_terc4 = ^{terc4, IS_LANE0};
`endif

   always_comb begin
      n1_d     = ones8(vid_data);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !vid_data[0]);
      chain    = vid_data[0];
      q_m_next = '0;
      q_m_next[0] = chain;
      for (int i = 1; i < 8; i++) begin
         chain       = use_xnor ? ~(chain ^ vid_data[i]) : (chain ^ vid_data[i]);
         q_m_next[i] = chain;
      end
      q_m_next[8] = ~use_xnor;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1 <= MODE_CTRL;
         q_m_s1  <= '0;
         ctrl_s1 <= '0;
`ifdef TMDS_TERC4_EN
         terc4_s1 <= '0;
`endif
      end else begin
         mode_s1 <= decode_mode(mode);
         q_m_s1  <= q_m_next;
         ctrl_s1 <= ctrl;
`ifdef TMDS_TERC4_EN
         terc4_s1 <= terc4;
`endif
      end
   end

   // bal is N1-N0 of q_m[7:0]; everything wraps in 5-bit signed arithmetic.
   always_comb begin
      n1_qm = ones8(q_m_s1[7:0]);
      n1_s  = $signed({1'b0, n1_qm});
      bal   = n1_s + n1_s - 5'sd8;
      if ((cnt == 5'sd0) || (n1_qm == 4'd4)) begin
         video_sym = {~q_m_s1[8], q_m_s1[8], q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
         video_cnt = q_m_s1[8] ? (cnt + bal) : (cnt - bal);
      end else if (((cnt > 5'sd0) && (n1_qm > 4'd4)) || ((cnt < 5'sd0) && (n1_qm < 4'd4))) begin
         video_sym = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
         video_cnt = cnt + (q_m_s1[8] ? 5'sd2 : 5'sd0) - bal;
      end else begin
         video_sym = {1'b0, q_m_s1[8], q_m_s1[7:0]};
         video_cnt = cnt - (q_m_s1[8] ? 5'sd0 : 5'sd2) + bal;
      end

      q_next   = ctrl_symbol(ctrl_s1);
      cnt_next = 5'sd0;
      case (mode_s1)
         MODE_VIDEO: begin
            q_next   = video_sym;
            cnt_next = video_cnt;
         end
         MODE_VID_GB:   q_next = GB_USE_B ? GB_PATTERN_B : GB_PATTERN_A;
`ifdef TMDS_TERC4_EN
         MODE_DATA_GB:  q_next = IS_LANE0 ? terc4_symbol(terc4_s1) : GB_PATTERN_B;
         MODE_DATA_ISL: q_next = terc4_symbol(terc4_s1);
`endif
         default:       q_next = ctrl_symbol(ctrl_s1);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= CTRL_SYM_00;
         cnt <= 5'sd0;
      end else begin
         q   <= q_next;
         cnt <= cnt_next;
      end
   end

   assign disp = cnt;

endmodule

// File: rtl/tmds_period_encoder.sv
// Multi-lane TMDS period encoder with 2-cycle latency.
// Define TMDS_TERC4_EN to enable TERC4 data-island and data guard-band symbols.
module tmds_period_encoder
   import tmds_pkg::*;
#(
   parameter int         NUM_CH            = 3,
   parameter logic [7:0] GB_PATTERN_B_MASK = 8'b0000_0010
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            mode,
   input  logic [NUM_CH*8-1:0]   vid_data,
   input  logic [NUM_CH*2-1:0]   ctrl,
   input  logic [NUM_CH*4-1:0]   terc4,
   output logic [NUM_CH*10-1:0]  q,
   output logic [NUM_CH*5-1:0]   disp
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      tmds_lane #(
         .GB_USE_B (GB_PATTERN_B_MASK[i]),
         .IS_LANE0 (i == 0)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .mode     (mode),
         .vid_data (vid_data[8*i +: 8]),
         .ctrl     (ctrl[2*i +: 2]),
         .terc4    (terc4[4*i +: 4]),
         .q        (q[10*i +: 10]),
         .disp     (disp[5*i +: 5])
      );
   end

endmodule

// File: tb/tb_tmds_period_encoder.sv
// Self-checking bench for tmds_period_encoder: directed symbol checks plus random
// streams against a running-disparity reference model.
module tb_tmds_period_encoder;

   localparam int         NUM_CH  = 3;
   localparam logic [7:0] GB_MASK = 8'b0000_0010;
   localparam logic [2:0] M_CTRL  = 3'd0;
   localparam logic [2:0] M_VIDGB = 3'd1;
   localparam logic [2:0] M_VIDEO = 3'd2;
   localparam logic [2:0] M_DGB   = 3'd3;
   localparam logic [2:0] M_ISL   = 3'd4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [2:0]           mode = '0;
   logic [NUM_CH*8-1:0]  vid_data = '0;
   logic [NUM_CH*2-1:0]  ctrl = '0;
   logic [NUM_CH*4-1:0]  terc4 = '0;
   logic [NUM_CH*10-1:0] q;
   logic [NUM_CH*5-1:0]  disp;

   int total = 0;
   int bad   = 0;

   logic [NUM_CH*10-1:0] exp_q [$];
   logic [NUM_CH*10-1:0] obs_q [$];
   logic [NUM_CH*5-1:0]  exp_d [$];
   logic [NUM_CH*5-1:0]  obs_d [$];
   int                   model_cnt [NUM_CH];

   logic [9:0] terc4_ref [16] = '{
      10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
   };

   tmds_period_encoder #(
      .NUM_CH            (NUM_CH),
      .GB_PATTERN_B_MASK (GB_MASK)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .vid_data (vid_data),
      .ctrl     (ctrl),
      .terc4    (terc4),
      .q        (q),
      .disp     (disp)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
      case (c)
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   // Video disparity is simply ones minus zeros of each emitted symbol.
   task automatic model_lane(input int lane, input logic [2:0] m, input logic [7:0] d,
                             input logic [1:0] c, input logic [3:0] t, input int cnt_in,
                             output logic [9:0] sym, output int cnt_out);
      int         n1;
      logic       inv_chain;
      logic [7:0] qm;
      logic       q8;
      cnt_out = 0;
      sym     = ctrl_ref(c);
      case (m)
         M_VIDEO: begin
            n1        = $countones(d);
            inv_chain = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0]     = d[0];
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ inv_chain;
            q8 = ~inv_chain;
            if (cnt_in == 0 || $countones(qm) == 4)
               sym = q8 ? {2'b01, qm} : {2'b10, ~qm};
            else if ((cnt_in > 0) == ($countones(qm) > 4))
               sym = {1'b1, q8, ~qm};
            else
               sym = {1'b0, q8, qm};
            cnt_out = cnt_in + 2 * $countones(sym) - 10;
         end
         M_VIDGB: sym = GB_MASK[lane] ? 10'h133 : 10'h2CC;
`ifdef TMDS_TERC4_EN
         M_DGB:   sym = (lane == 0) ? terc4_ref[t] : 10'h133;
         M_ISL:   sym = terc4_ref[t];
`endif
         default: sym = ctrl_ref(c);
      endcase
   endtask

   // Records the current outputs, applies one cycle of inputs, advances to next negedge.
   task automatic drive(input logic [2:0] m, input logic [NUM_CH*8-1:0] vd,
                        input logic [NUM_CH*2-1:0] c, input logic [NUM_CH*4-1:0] t);
      logic [NUM_CH*10-1:0] eq;
      logic [NUM_CH*5-1:0]  ed;
      logic [9:0]           s;
      int                   nc;
      obs_q.push_back(q);
      obs_d.push_back(disp);
      mode = m; vid_data = vd; ctrl = c; terc4 = t;
      for (int l = 0; l < NUM_CH; l++) begin
         model_lane(l, m, vd[8*l +: 8], c[2*l +: 2], t[4*l +: 4], model_cnt[l], s, nc);
         model_cnt[l]    = nc;
         eq[10*l +: 10]  = s;
         ed[5*l +: 5]    = nc[4:0];
      end
      exp_q.push_back(eq);
      exp_d.push_back(ed);
      @(negedge clk);
   endtask

   task automatic release_reset();
      exp_q.delete(); obs_q.delete(); exp_d.delete(); obs_d.delete();
      repeat (2) begin
         exp_q.push_back({NUM_CH{10'h354}});
         exp_d.push_back('0);
      end
      for (int l = 0; l < NUM_CH; l++) model_cnt[l] = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = M_CTRL; ctrl = '0; vid_data = '0; terc4 = '0;
      repeat (2) @(negedge clk);
      for (int l = 0; l < NUM_CH; l++) begin
         total++;
         if (q[10*l +: 10] !== 10'h354) begin
            bad++; $display("[TB] FAIL reset_q lane=%0d got=%h want=354", l, q[10*l +: 10]);
         end
         total++;
         if (disp[5*l +: 5] !== 5'd0) begin
            bad++; $display("[TB] FAIL reset_disp lane=%0d got=%h want=0", l, disp[5*l +: 5]);
         end
      end
      release_reset();
      repeat (5) drive(M_VIDEO, 24'($urandom), 6'($urandom), 12'($urandom));
      for (int k = 0; k < obs_q.size(); k++) begin
         total++;
         if (obs_q[k] !== exp_q[k] || obs_d[k] !== exp_d[k]) begin
            bad++;
            $display("[TB] FAIL post_reset idx=%0d got q=%h d=%h want q=%h d=%h",
                     k, obs_q[k], obs_d[k], exp_q[k], exp_d[k]);
         end
      end
      drive(M_CTRL, '0, '0, '0);
      drive(M_CTRL, '0, '0, '0);
   endtask

   task automatic test_video_zero();
      int         start;
      logic [9:0] want_q [3];
      int         want_d [3];
      logic signed [4:0] dv;
      want_q = '{10'h100, 10'h3FF, 10'h100};
      want_d = '{-8, 2, -6};
      start  = obs_q.size();
      repeat (3) drive(M_VIDEO, '0, '0, '0);
      repeat (3) drive(M_CTRL, '0, '0, '0);
      for (int j = 0; j < 3; j++) begin
         for (int l = 0; l < NUM_CH; l++) begin
            dv = obs_d[start+j+2][5*l +: 5];
            total++;
            if (obs_q[start+j+2][10*l +: 10] !== want_q[j] || int'(dv) != want_d[j]) begin
               bad++;
               $display("[TB] FAIL video_zero sym=%0d lane=%0d got q=%h d=%0d want q=%h d=%0d",
                        j, l, obs_q[start+j+2][10*l +: 10], dv, want_q[j], want_d[j]);
            end
         end
      end
   endtask

   task automatic test_ctrl_restart();
      int start;
      logic signed [4:0] dv;
      start = obs_q.size();
      drive(M_VIDEO, '0, '0, '0);
      drive(M_CTRL, '0, '0, '0);
      drive(M_VIDEO, '0, '0, '0);
      repeat (3) drive(M_CTRL, '0, '0, '0);
      dv = obs_d[start+2][4:0];
      total++;
      if (obs_q[start+2][9:0] !== 10'h100 || dv !== -5'sd8) begin
         bad++; $display("[TB] FAIL restart_first got q=%h d=%0d want q=100 d=-8", obs_q[start+2][9:0], dv);
      end
      dv = obs_d[start+3][4:0];
      total++;
      if (obs_q[start+3][9:0] !== 10'h354 || dv !== 5'sd0) begin
         bad++; $display("[TB] FAIL restart_ctrl got q=%h d=%0d want q=354 d=0", obs_q[start+3][9:0], dv);
      end
      dv = obs_d[start+4][4:0];
      total++;
      if (obs_q[start+4][9:0] !== 10'h100 || dv !== -5'sd8) begin
         bad++; $display("[TB] FAIL restart_second got q=%h d=%0d want q=100 d=-8", obs_q[start+4][9:0], dv);
      end
   endtask

   task automatic test_vid_gb();
      int         start;
      logic [9:0] want [3];
      want  = '{10'h2CC, 10'h133, 10'h2CC};
      start = obs_q.size();
      drive(M_VIDGB, 24'($urandom), 6'($urandom), 12'($urandom));
      repeat (3) drive(M_CTRL, '0, '0, '0);
      for (int l = 0; l < NUM_CH; l++) begin
         total++;
         if (obs_q[start+2][10*l +: 10] !== want[l]) begin
            bad++; $display("[TB] FAIL vid_gb lane=%0d got=%h want=%h", l, obs_q[start+2][10*l +: 10], want[l]);
         end
      end
   endtask

   task automatic test_data_isl();
      int         start;
      logic [9:0] want;
`ifdef TMDS_TERC4_EN
      want = 10'h29C;
`else
      want = 10'h0AB;
`endif
      start = obs_q.size();
      drive(M_ISL, '0, 6'b01_01_01, '0);
      repeat (3) drive(M_CTRL, '0, '0, '0);
      for (int l = 0; l < NUM_CH; l++) begin
         total++;
         if (obs_q[start+2][10*l +: 10] !== want) begin
            bad++; $display("[TB] FAIL data_isl lane=%0d got=%h want=%h", l, obs_q[start+2][10*l +: 10], want);
         end
      end
   endtask

   task automatic test_random_modes();
      int start;
      start = obs_q.size();
      repeat (2000)
         drive(3'($urandom_range(0, 7)), 24'($urandom), 6'($urandom), 12'($urandom));
      repeat (2) drive(M_CTRL, '0, '0, '0);
      for (int k = start; k < obs_q.size(); k++) begin
         total++;
         if (obs_q[k] !== exp_q[k] || obs_d[k] !== exp_d[k]) begin
            bad++;
            $display("[TB] FAIL random_modes idx=%0d got q=%h d=%h want q=%h d=%h",
                     k, obs_q[k], obs_d[k], exp_q[k], exp_d[k]);
         end
      end
   endtask

   task automatic test_video_stress_reset();
      int start;
      logic signed [4:0] dv;
      start = obs_q.size();
      repeat (10000) drive(M_VIDEO, 24'($urandom), 6'($urandom), 12'($urandom));
      for (int k = start; k < obs_q.size(); k++) begin
         total++;
         if (obs_q[k] !== exp_q[k] || obs_d[k] !== exp_d[k]) begin
            bad++;
            $display("[TB] FAIL video_stream idx=%0d got q=%h d=%h want q=%h d=%h",
                     k, obs_q[k], obs_d[k], exp_q[k], exp_d[k]);
         end
         for (int l = 0; l < NUM_CH; l++) begin
            dv = obs_d[k][5*l +: 5];
            total++;
            if (dv > 5'sd10 || dv < -5'sd10) begin
               bad++; $display("[TB] FAIL disp_range idx=%0d lane=%0d got=%0d want |d|<=10", k, l, dv);
            end
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int l = 0; l < NUM_CH; l++) begin
         total++;
         if (q[10*l +: 10] !== 10'h354 || disp[5*l +: 5] !== 5'd0) begin
            bad++;
            $display("[TB] FAIL midstream_reset lane=%0d got q=%h d=%h want q=354 d=0",
                     l, q[10*l +: 10], disp[5*l +: 5]);
         end
      end
      repeat (2) @(negedge clk);
      release_reset();
   endtask

   initial begin
      test_reset();
      test_video_zero();
      test_ctrl_restart();
      test_vid_gb();
      test_data_isl();
      test_random_modes();
      test_video_stress_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
